i2c_slave_regif: RTL and testbench

- I2C responder (slave) that answers the sensor-configuration master.
- Frame format: 7-bit device ID, 2-byte register address, 1-byte data per register, with auto-increment.
- Synthesizable; used as a sensor model in simulation and as a target on debug boards.
- Converts bus writes and reads into a single-cycle register-port interface toward an external register store.

---
 rtl/i2c_slave_regif.sv | 204 ++++++++++++++++++++
 tb/tb_i2c_slave_regif.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regif.sv
// I2C target with 16-bit register pointer and auto-increment, bridging bus
// transfers onto a single-cycle register read/write port.
module i2c_slave_regif #(
  parameter logic [6:0] DEV_ADDR = 7'h6C
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        reg_wr,
  output logic        reg_rd,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  input  logic [7:0]  reg_rdata,
  output logic        busy,
  output logic        start_det,
  output logic        stop_det
);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_DEV_ACK, S_AHI, S_AHI_ACK, S_ALO, S_ALO_ACK,
    S_WR, S_WR_ACK, S_RD, S_RD_MACK, S_IGNORE
  } state_t;

  state_t      r_state;
  logic        r_scl_s1, r_scl_s2, r_scl_d;
  logic        r_sda_s1, r_sda_s2, r_sda_d;
  logic [2:0]  r_bitcnt;
  logic [6:0]  r_shift;
  logic [7:0]  r_tx;
  logic        r_ack_drv;
  logic        r_rw;
  logic        r_rd_d;
  logic        r_sda_oe, r_reg_wr, r_reg_rd, r_busy, r_start_det, r_stop_det;
  logic [15:0] r_reg_addr;
  logic [7:0]  r_reg_wdata;

  logic        w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]  w_byte;
  logic [2:0]  w_tx_idx;

  // Bus idles high, so the synchronizers reset to 1 to avoid a fake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= 3'b111;
      {r_sda_s1, r_sda_s2, r_sda_d} <= 3'b111;
    end else begin
      {r_scl_s1, r_scl_s2, r_scl_d} <= {scl_i, r_scl_s1, r_scl_s2};
      {r_sda_s1, r_sda_s2, r_sda_d} <= {sda_i, r_sda_s1, r_sda_s2};
    end
  end

  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_byte     = {r_shift, r_sda_s2};
  assign w_tx_idx   = 3'd7 - r_bitcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_bitcnt    <= 3'd0;
      r_shift     <= 7'd0;
      r_tx        <= 8'd0;
      r_ack_drv   <= 1'b0;
      r_rw        <= 1'b0;
      r_rd_d      <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_reg_wr    <= 1'b0;
      r_reg_rd    <= 1'b0;
      r_busy      <= 1'b0;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      r_reg_addr  <= 16'd0;
      r_reg_wdata <= 8'd0;
    end else begin
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      r_reg_wr    <= 1'b0;
      r_reg_rd    <= 1'b0;
      r_rd_d      <= r_reg_rd;
      if (r_reg_wr) r_reg_addr <= r_reg_addr + 16'd1;
      if (r_rd_d)   r_tx <= reg_rdata;

      if (w_stop) begin
        r_state    <= S_IDLE;
        r_sda_oe   <= 1'b0;
        r_busy     <= 1'b0;
        r_stop_det <= 1'b1;
      end else if (w_start) begin
        r_state     <= S_DEV;
        r_bitcnt    <= 3'd0;
        r_sda_oe    <= 1'b0;
        r_ack_drv   <= 1'b0;
        r_start_det <= 1'b1;
      end else begin
        case (r_state)
          S_DEV, S_AHI, S_ALO, S_WR: begin
            if (w_scl_rise) begin
              r_shift  <= w_byte[6:0];
              r_bitcnt <= r_bitcnt + 3'd1;
              if (r_bitcnt == 3'd7) begin
                r_ack_drv <= 1'b0;
                case (r_state)
                  S_DEV: begin
                    if (w_byte[7:1] == DEV_ADDR) begin
                      r_busy  <= 1'b1;
                      r_rw    <= w_byte[0];
                      r_state <= S_DEV_ACK;
                    end else begin
                      r_state <= S_IGNORE;
                    end
                  end
                  S_AHI: begin
                    r_reg_addr[15:8] <= w_byte;
                    r_state          <= S_AHI_ACK;
                  end
                  S_ALO: begin
                    r_reg_addr[7:0] <= w_byte;
                    r_state         <= S_ALO_ACK;
                  end
                  default: begin
                    r_reg_wdata <= w_byte;
                    r_reg_wr    <= 1'b1;
                    r_state     <= S_WR_ACK;
                  end
                endcase
              end
            end
          end
          S_DEV_ACK, S_AHI_ACK, S_ALO_ACK, S_WR_ACK: begin
            // First fall drives ACK, second fall ends the ACK clock.
            if (w_scl_rise && r_ack_drv && r_state == S_DEV_ACK && r_rw)
              r_reg_rd <= 1'b1;
            if (w_scl_fall) begin
              if (!r_ack_drv) begin
                r_sda_oe  <= 1'b1;
                r_ack_drv <= 1'b1;
              end else begin
                r_ack_drv <= 1'b0;
                r_bitcnt  <= 3'd0;
                r_sda_oe  <= 1'b0;
                case (r_state)
                  S_DEV_ACK: begin
                    if (r_rw) begin
                      r_state  <= S_RD;
                      r_sda_oe <= ~r_tx[7];
                    end else begin
                      r_state <= S_AHI;
                    end
                  end
                  S_AHI_ACK: r_state <= S_ALO;
                  default:   r_state <= S_WR;
                endcase
              end
            end
          end
          S_RD: begin
            if (w_scl_rise) r_bitcnt <= r_bitcnt + 3'd1;
            if (w_scl_fall) begin
              if (r_bitcnt == 3'd0) begin
                r_sda_oe  <= 1'b0;
                r_ack_drv <= 1'b0;
                r_state   <= S_RD_MACK;
              end else begin
                r_sda_oe <= ~r_tx[w_tx_idx];
              end
            end
          end
          S_RD_MACK: begin
            if (w_scl_rise) begin
              r_reg_addr <= r_reg_addr + 16'd1;
              if (!r_sda_s2) begin
                r_reg_rd  <= 1'b1;
                r_ack_drv <= 1'b1;
              end else begin
                r_state <= S_IGNORE;
              end
            end
            if (w_scl_fall && r_ack_drv) begin
              r_ack_drv <= 1'b0;
              r_bitcnt  <= 3'd0;
              r_sda_oe  <= ~r_tx[7];
              r_state   <= S_RD;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign reg_wr    = r_reg_wr;
  assign reg_rd    = r_reg_rd;
  assign reg_addr  = r_reg_addr;
  assign reg_wdata = r_reg_wdata;
  assign busy      = r_busy;
  assign start_det = r_start_det;
  assign stop_det  = r_stop_det;

endmodule

// File: tb/tb_i2c_slave_regif.sv
// Bus-master model driving i2c_slave_regif; strobes and read bytes are
// checked against expectations queued when the stimulus is issued.
module tb_i2c_slave_regif;
  localparam int Q = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_scl = 1'b1;
  logic        m_sda = 1'b1;
  logic        scl_i, sda_i;
  logic        sda_oe, reg_wr, reg_rd, busy, start_det, stop_det;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata = 8'd0;

  int n_checks = 0;
  int n_fail = 0;
  int n_start = 0, n_stop = 0, n_wr = 0, n_rd = 0, n_oe = 0;

  logic [23:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  exp_bus[$];

  assign scl_i = m_scl;
  assign sda_i = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regif #(.DEV_ADDR(7'h6C)) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_rdata(reg_rdata), .busy(busy), .start_det(start_det), .stop_det(stop_det)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Register store: returns addr[7:0], valid the cycle after reg_rd.
  always @(posedge clk) if (reg_rd) reg_rdata <= reg_addr[7:0];

  always @(negedge clk) begin
    if (rst_n) begin
      if (start_det) n_start++;
      if (stop_det)  n_stop++;
      if (sda_oe)    n_oe++;
      if (reg_wr | reg_rd) check_val("wr_rd_excl", 32'(reg_wr & reg_rd), 32'd0);
      if (reg_wr) begin
        n_wr++;
        check_val("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
        if (exp_wr.size() > 0) begin
          logic [23:0] e;
          e = exp_wr.pop_front();
          check_val("wr_addr", 32'(reg_addr), 32'(e[23:8]));
          check_val("wr_data", 32'(reg_wdata), 32'(e[7:0]));
        end
      end
      if (reg_rd) begin
        n_rd++;
        check_val("rd_expected", 32'(exp_rd.size() > 0), 32'd1);
        if (exp_rd.size() > 0) check_val("rd_addr", 32'(reg_addr), 32'(exp_rd.pop_front()));
      end
    end
  end

  task automatic q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    m_sda = 1'b1; q(); m_scl = 1'b1; q(); m_sda = 1'b0; q(); m_scl = 1'b0; q();
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; q(); m_scl = 1'b1; q(); m_sda = 1'b1; q();
  endtask

  task automatic put_bit(input logic b);
    m_sda = b; q(); m_scl = 1'b1; q(); q(); m_scl = 1'b0; q();
  endtask

  task automatic get_bit(output logic b);
    m_sda = 1'b1; q(); m_scl = 1'b1; q(); b = sda_i; q(); m_scl = 1'b0; q();
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(input logic mack, output logic [7:0] d);
    logic b;
    d = 8'd0;
    for (int i = 0; i < 8; i++) begin
      get_bit(b);
      d = {d[6:0], b};
    end
    put_bit(mack);
  endtask

  task automatic send_acked(input string tag, input logic [7:0] d);
    logic ack;
    put_byte(d, ack);
    check_val(tag, 32'(ack), 32'd0);
  endtask

  initial begin
    logic        ack;
    logic [7:0]  d;
    int          s0, p0, w0, r0, o0;

    repeat (4) @(negedge clk);
    check_val("reset_outputs", 32'({sda_oe, reg_wr, reg_rd, busy, start_det, stop_det, reg_addr, reg_wdata}), 32'd0);
    rst_n = 1'b1;
    q();

    // Single write 0xA5 to 0x3012
    s0 = n_start; p0 = n_stop;
    bus_start();
    send_acked("w1_dev_ack", 8'hD8);
    check_val("w1_busy", 32'(busy), 32'd1);
    send_acked("w1_ahi_ack", 8'h30);
    send_acked("w1_alo_ack", 8'h12);
    exp_wr.push_back({16'h3012, 8'hA5});
    send_acked("w1_data_ack", 8'hA5);
    bus_stop(); q();
    check_val("w1_busy_end", 32'(busy), 32'd0);
    check_val("w1_start_cnt", 32'(n_start - s0), 32'd1);
    check_val("w1_stop_cnt", 32'(n_stop - p0), 32'd1);
    check_val("w1_wr_pending", 32'(exp_wr.size()), 32'd0);

    // Burst write across the pointer wrap
    bus_start();
    send_acked("bw_dev_ack", 8'hD8);
    send_acked("bw_ahi_ack", 8'hFF);
    send_acked("bw_alo_ack", 8'hFF);
    exp_wr.push_back({16'hFFFF, 8'h11});
    send_acked("bw_d0_ack", 8'h11);
    exp_wr.push_back({16'h0000, 8'h22});
    send_acked("bw_d1_ack", 8'h22);
    exp_wr.push_back({16'h0001, 8'h33});
    send_acked("bw_d2_ack", 8'h33);
    bus_stop(); q();
    check_val("bw_wr_pending", 32'(exp_wr.size()), 32'd0);
    check_val("bw_addr_end", 32'(reg_addr), 32'h0002);

    // Random read: set pointer, repeated START, read two bytes
    r0 = n_rd;
    bus_start();
    send_acked("rr_dev_ack", 8'hD8);
    send_acked("rr_ahi_ack", 8'h30);
    send_acked("rr_alo_ack", 8'h12);
    bus_start();
    exp_rd.push_back(16'h3012);
    exp_bus.push_back(8'h12);
    send_acked("rr_devr_ack", 8'hD9);
    exp_rd.push_back(16'h3013);
    get_byte(1'b0, d);
    check_val("rr_byte0", 32'(d), 32'(exp_bus.pop_front()));
    exp_bus.push_back(8'h13);
    get_byte(1'b1, d);
    check_val("rr_byte1", 32'(d), 32'(exp_bus.pop_front()));
    bus_stop(); q();
    check_val("rr_rd_cnt", 32'(n_rd - r0), 32'd2);
    check_val("rr_rd_pending", 32'(exp_rd.size()), 32'd0);
    check_val("rr_addr_end", 32'(reg_addr), 32'h3014);
    check_val("rr_busy_end", 32'(busy), 32'd0);

    // Wrong device address: bus must stay untouched
    o0 = n_oe; w0 = n_wr; r0 = n_rd;
    bus_start();
    put_byte(8'hA0, ack);
    check_val("wd_nack", 32'(ack), 32'd1);
    check_val("wd_busy", 32'(busy), 32'd0);
    put_byte(8'h00, ack);
    put_byte(8'h00, ack);
    bus_stop(); q();
    check_val("wd_oe_cycles", 32'(n_oe - o0), 32'd0);
    check_val("wd_strobes", 32'((n_wr - w0) + (n_rd - r0)), 32'd0);

    // Abort mid data byte, then a normal frame
    w0 = n_wr;
    bus_start();
    send_acked("ab_dev_ack", 8'hD8);
    send_acked("ab_ahi_ack", 8'h00);
    send_acked("ab_alo_ack", 8'h05);
    put_bit(1'b1); put_bit(1'b0); put_bit(1'b1); put_bit(1'b0);
    bus_stop(); q();
    check_val("ab_no_wr", 32'(n_wr - w0), 32'd0);
    check_val("ab_busy", 32'(busy), 32'd0);
    bus_start();
    send_acked("ab2_dev_ack", 8'hD8);
    send_acked("ab2_ahi_ack", 8'h00);
    send_acked("ab2_alo_ack", 8'h06);
    exp_wr.push_back({16'h0006, 8'h5A});
    send_acked("ab2_data_ack", 8'h5A);
    bus_stop(); q();
    check_val("ab2_wr_pending", 32'(exp_wr.size()), 32'd0);

    // Reset while the target drives a 0 data bit
    bus_start();
    send_acked("rs_dev_ack", 8'hD8);
    send_acked("rs_ahi_ack", 8'h00);
    send_acked("rs_alo_ack", 8'h00);
    bus_start();
    exp_rd.push_back(16'h0000);
    send_acked("rs_devr_ack", 8'hD9);
    check_val("rs_driving", 32'(sda_oe), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("rs_oe_async", 32'(sda_oe), 32'd0);
    check_val("rs_outputs", 32'({sda_oe, reg_wr, reg_rd, busy, start_det, stop_det, reg_addr, reg_wdata}), 32'd0);
    m_scl = 1'b1; m_sda = 1'b1;
    q();
    rst_n = 1'b1;
    q();
    check_val("rs_rd_pending", 32'(exp_rd.size()), 32'd0);
    check_val("rs_idle_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
